// File: rtl/seq_det_pkg.sv
// Shared defaults and types for the sequence detector and its event logger.
// Timestamp width, queue depth and counter width live here.
package seq_det_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 8;

    typedef struct packed {
        logic [TS_W_DEF-1:0] ts;
    } seq_evt_t;

endpackage

// File: rtl/seq_evt_fifo.sv
// Show-ahead synchronous FIFO holding detection timestamps.
// Pointers carry a wrap bit so full and empty differ only in the MSB.
module seq_evt_fifo
    import seq_det_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = TS_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  wr_ptr_d;
    logic [AW:0]  rd_ptr_q;
    logic [AW:0]  rd_ptr_d;
    logic         wr_en;
    logic         rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;

    // A pop frees the slot a simultaneous push needs when full.
    assign rd_en = pop && !empty && !clear;
    assign wr_en = push && (!full || rd_en) && !clear;

    assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/sequence_event_logger.sv
// Timestamps detector pulses into a FIFO for a valid/ready consumer,
// with saturating detection/drop counters, sticky overflow and irq.
module sequence_event_logger
    import seq_det_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sequence_found,
    input  logic                   clear,
    input  logic                   evt_ready,
    output logic                   evt_valid,
    output logic [TS_W-1:0]        evt_timestamp,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]       det_count,
    output logic [CNT_W-1:0]       drop_count,
    output logic                   overflow,
    output logic                   irq
);

    localparam logic [TS_W-1:0]  TS_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [TS_W-1:0]  ts_q;
    logic [TS_W-1:0]  ts_d;
    logic [CNT_W-1:0] det_q;
    logic [CNT_W-1:0] det_d;
    logic [CNT_W-1:0] drop_q;
    logic [CNT_W-1:0] drop_d;
    logic             ovf_q;
    logic             ovf_d;

    logic push_req;
    logic pop_req;
    logic drop;
    logic full;
    logic empty;

    assign push_req = sequence_found && !clear;
    assign pop_req  = evt_ready && !empty;
    assign drop     = push_req && full && !pop_req;

    seq_evt_fifo #(
        .DEPTH (DEPTH),
        .W     (TS_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .push    (push_req),
        .pop     (evt_ready),
        .wdata   (ts_q),
        .rdata   (evt_timestamp),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    always_comb begin
        ts_d   = ts_q + TS_ONE;
        det_d  = det_q;
        drop_d = drop_q;
        ovf_d  = ovf_q;
        if (clear) begin
            det_d  = '0;
            drop_d = '0;
            ovf_d  = 1'b0;
        end else begin
            if (push_req && (det_q != '1)) begin
                det_d = det_q + CNT_ONE;
            end
            if (drop && (drop_q != '1)) begin
                drop_d = drop_q + CNT_ONE;
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q   <= '0;
            det_q  <= '0;
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            ts_q   <= ts_d;
            det_q  <= det_d;
            drop_q <= drop_d;
            ovf_q  <= ovf_d;
        end
    end

    assign evt_valid  = !empty;
    assign det_count  = det_q;
    assign drop_count = drop_q;
    assign overflow   = ovf_q;
    assign irq        = evt_valid | ovf_q;

endmodule

// File: tb/tb_sequence_event_logger.sv
// Randomised and directed checks of the event logger against a
// queue-based reference model.
module tb_sequence_event_logger;

    localparam int TS_W    = 16;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 8;
    localparam int TS_MOD  = 1 << TS_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset_n;
    logic             sequence_found;
    logic             clear;
    logic             evt_ready;
    logic             evt_valid;
    logic [TS_W-1:0]  evt_timestamp;
    logic [2:0]       fifo_level;
    logic [CNT_W-1:0] det_count;
    logic [CNT_W-1:0] drop_count;
    logic             overflow;
    logic             irq;

    sequence_event_logger #(
        .TS_W  (TS_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sequence_found (sequence_found),
        .clear          (clear),
        .evt_ready      (evt_ready),
        .evt_valid      (evt_valid),
        .evt_timestamp  (evt_timestamp),
        .fifo_level     (fifo_level),
        .det_count      (det_count),
        .drop_count     (drop_count),
        .overflow       (overflow),
        .irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;

    int          m_ts;
    int unsigned m_q[$];
    int          m_det;
    int          m_drop;
    bit          m_ovf;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int unsigned head;
        head = (m_q.size() != 0) ? m_q[0] : 0;
        chk("valid", 32'(evt_valid), 32'(m_q.size() != 0));
        chk("head", 32'(evt_timestamp), head);
        chk("level", 32'(fifo_level), m_q.size());
        chk("det", 32'(det_count), m_det);
        chk("drop", 32'(drop_count), m_drop);
        chk("ovf", 32'(overflow), 32'(m_ovf));
        chk("irq", 32'(irq), 32'((m_q.size() != 0) || m_ovf));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ts   = 0;
        m_det  = 0;
        m_drop = 0;
        m_ovf  = 1'b0;
    endtask

    // Drive one cycle, advance the model by the documented rules, check.
    task automatic cyc(input bit sf, input bit rdy, input bit clr);
        bit was_full;
        bit pop;
        sequence_found = sf;
        evt_ready      = rdy;
        clear          = clr;
        @(posedge clk);
        if (clr) begin
            m_q.delete();
            m_det  = 0;
            m_drop = 0;
            m_ovf  = 1'b0;
        end else begin
            was_full = (m_q.size() == DEPTH);
            pop      = rdy && (m_q.size() != 0);
            if (sf) begin
                if (m_det < CNT_MAX) m_det++;
                if (was_full && !pop) begin
                    if (m_drop < CNT_MAX) m_drop++;
                    m_ovf = 1'b1;
                end
            end
            if (pop) void'(m_q.pop_front());
            if (sf && !(was_full && !pop)) m_q.push_back(m_ts);
        end
        m_ts = (m_ts + 1) % TS_MOD;
        #1;
        check_all();
    endtask

    initial begin
        n_chk          = 0;
        n_pass         = 0;
        reset_n        = 1'b0;
        sequence_found = 1'b0;
        clear          = 1'b0;
        evt_ready      = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;

        // Single pulse at ts=5, then pop.
        repeat (5) cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("t1_valid", 32'(evt_valid), 1);
        chk("t1_ts", 32'(evt_timestamp), 5);
        chk("t1_level", 32'(fifo_level), 1);
        chk("t1_det", 32'(det_count), 1);
        chk("t1_irq", 32'(irq), 1);
        cyc(0, 1, 0);
        chk("t1_pop_valid", 32'(evt_valid), 0);
        chk("t1_pop_ts", 32'(evt_timestamp), 0);

        // Six pulses from ts=10 into a depth-4 queue.
        cyc(0, 0, 1);
        repeat (2) cyc(0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0);
        chk("burst_head", 32'(evt_timestamp), 10);
        chk("burst_level", 32'(fifo_level), 4);
        chk("burst_det", 32'(det_count), 6);
        chk("burst_drop", 32'(drop_count), 2);
        chk("burst_ovf", 32'(overflow), 1);

        // Full with simultaneous pop and push at ts=16.
        cyc(1, 1, 0);
        chk("fullpp_head", 32'(evt_timestamp), 11);
        chk("fullpp_level", 32'(fifo_level), 4);
        chk("fullpp_drop", 32'(drop_count), 2);
        chk("fullpp_det", 32'(det_count), 7);

        // Clear beats a pulse and a pop; ts keeps running.
        cyc(1, 1, 1);
        chk("clr_level", 32'(fifo_level), 0);
        chk("clr_det", 32'(det_count), 0);
        chk("clr_drop", 32'(drop_count), 0);
        chk("clr_ovf", 32'(overflow), 0);
        cyc(1, 0, 0);
        chk("clr_ts", 32'(evt_timestamp), 18);
        cyc(0, 1, 0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 63) == 0));
        end

        // Counter saturation with continuous pop.
        cyc(0, 1, 1);
        for (int i = 0; i < 300; i++) cyc(1, 1, 0);
        chk("sat_det", 32'(det_count), CNT_MAX);
        chk("sat_drop", 32'(drop_count), 0);

        // Timestamp wrap.
        cyc(0, 0, 1);
        while (m_ts != TS_MOD - 1) cyc(0, 1, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("wrap_hi", 32'(evt_timestamp), 32'hFFFF);
        cyc(0, 1, 0);
        chk("wrap_lo", 32'(evt_timestamp), 0);
        cyc(0, 1, 0);

        // Asynchronous reset with three entries queued.
        for (int i = 0; i < 3; i++) cyc(1, 0, 0);
        chk("pre_rst_level", 32'(fifo_level), 3);
        sequence_found = 1'b1;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        sequence_found = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;
        repeat (3) cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("post_rst_ts", 32'(evt_timestamp), 3);
        chk("post_rst_det", 32'(det_count), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
